// File: rtl/frame_cmd_decoder.sv
// Command frame decoder: turns synchronized bytes into register-file
// write/read strobes and pushes read results toward the TX FIFO.
module frame_cmd_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD = 8'hBB,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_full,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timeout fires on the edge where the count would reach TIMEOUT_CYCLES-1
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_PUSH
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0] rf_addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] txd_nxt;
  logic                  wr_nxt;
  logic                  rd_nxt;
  logic                  txv_nxt;
  logic                  err_nxt;
  logic                  counted;
  logic                  tmo;

  always_comb begin
    counted = (state == WR_ADDR) || (state == WR_DATA) ||
              (state == RD_ADDR) || (state == RD_WAIT);
    tmo     = counted && (cnt == TMO_LAST);
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    rf_addr_nxt = rf_addr;
    wdata_nxt   = rf_wr_data;
    txd_nxt     = tx_data;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    txv_nxt     = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = '0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == WR_CMD) begin
            state_nxt = WR_ADDR;
          end else if (rx_data == RD_CMD) begin
            state_nxt = RD_ADDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          addr_nxt  = rx_data[ADDR_WIDTH-1:0];
          state_nxt = WR_DATA;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wr_nxt      = 1'b1;
          rf_addr_nxt = addr_q;
          wdata_nxt   = rx_data;
          state_nxt   = IDLE;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          rd_nxt      = 1'b1;
          rf_addr_nxt = rx_data[ADDR_WIDTH-1:0];
          state_nxt   = RD_WAIT;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        // A byte here is an overrun: dropped, flagged, state kept
        err_nxt = rx_valid;
        if (rf_rd_valid) begin
          txd_nxt   = rf_rd_data;
          state_nxt = TX_PUSH;
        end else if (tmo) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      TX_PUSH: begin
        err_nxt = rx_valid;
        if (!tx_full) begin
          txv_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt == state && counted) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr_q     <= addr_nxt;
      rf_addr    <= rf_addr_nxt;
      rf_wr_data <= wdata_nxt;
      rf_wr_en   <= wr_nxt;
      rf_rd_en   <= rd_nxt;
      tx_data    <= txd_nxt;
      tx_valid   <= txv_nxt;
      frame_err  <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_frame_cmd_decoder.sv
// Scoreboard bench for frame_cmd_decoder: directed frames, then
// randomized frames checked against a frame-level reference model.
module tb_frame_cmd_decoder;

  localparam int T = 16;
  localparam logic [7:0] WR = 8'hAA;
  localparam logic [7:0] RD = 8'hBB;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_TX  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data = '0;
  logic       rf_rd_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_full = 1'b0;
  logic       frame_err;
  logic       busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  logic [7:0] model_mem [16];
  logic [7:0] rf_mem [16];

  frame_cmd_decoder #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .WR_CMD(WR),
    .RD_CMD(RD),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data),
    .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_full(tx_full),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Register file seen by the DUT
  always @(posedge CLK) begin
    if (!RST && rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(logic [1:0] k, logic [3:0] a,
                      logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(logic [1:0] k, logic [3:0] a,
                           logic [7:0] d);
    ev_t e;
    logic ok;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d a %0h d %0h, required none",
               k, a, d);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k);
      if (k == K_WR) ok = ok && e.addr == a && e.data == d;
      if (k == K_RD) ok = ok && e.addr == a;
      if (k == K_TX) ok = ok && e.data == d;
      if (!ok) begin
        n_fail++;
        $display("FAIL event: got kind %0d a %0h d %0h, required kind %0d a %0h d %0h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (rf_wr_en) pop_check(K_WR, rf_addr, rf_wr_data);
      if (rf_rd_en) pop_check(K_RD, rf_addr, 8'h00);
      if (tx_valid) pop_check(K_TX, 4'h0, tx_data);
      if (frame_err) pop_check(K_ERR, 4'h0, 8'h00);
      if (rf_wr_en && rf_rd_en) check("wr_rd_excl", 1, 0);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic rd_resp(logic [7:0] d);
    rf_rd_data  = d;
    rf_rd_valid = 1'b1;
    @(posedge CLK);
    #1;
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'($urandom);
  endtask

  task automatic wr_frame(logic [7:0] ab, logic [7:0] d,
                          int g1, int g2);
    send_byte(WR);
    idle(g1);
    send_byte(ab);
    idle(g2);
    push(K_WR, ab[3:0], d);
    model_mem[ab[3:0]] = d;
    send_byte(d);
  endtask

  task automatic rand_read();
    logic [7:0] ab;
    int ovr, lat, stall;
    ab    = 8'($urandom);
    ovr   = $urandom_range(0, 3) == 0 ? 1 : 0;
    lat   = $urandom_range(0, 13);
    stall = $urandom_range(0, 2) == 0 ? $urandom_range(1, 25) : 0;
    send_byte(RD);
    idle($urandom_range(0, T - 2));
    push(K_RD, ab[3:0], 8'h00);
    send_byte(ab);
    if (ovr != 0) begin
      push(K_ERR, 4'h0, 8'h00);
      send_byte(8'($urandom));
    end
    idle(lat);
    push(K_TX, 4'h0, model_mem[ab[3:0]]);
    tx_full = (stall > 0);
    rd_resp(rf_mem[rf_addr]);
    idle(stall);
    tx_full = 1'b0;
    idle(1);
  endtask

  task automatic rand_timeout();
    logic [7:0] ab;
    int kind;
    ab   = 8'($urandom);
    kind = $urandom_range(0, 3);
    send_byte(kind < 2 ? WR : RD);
    if (kind == 1) send_byte(ab);
    if (kind == 3) begin
      push(K_RD, ab[3:0], 8'h00);
      send_byte(ab);
    end
    push(K_ERR, 4'h0, 8'h00);
    idle(T);
  endtask

  initial begin : main
    int first;
    int cnt_bad;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      rf_mem[i]    = '0;
    end
    idle(3);
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_rd_en", rf_rd_en, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rf_addr", rf_addr, 0);
    RST = 1'b0;
    idle(2);

    // Write frame, pulses 4 cycles apart
    send_byte(WR);
    idle(3);
    check("wr_busy", busy, 1);
    send_byte(8'h05);
    idle(3);
    push(K_WR, 4'h5, 8'h3C);
    model_mem[5] = 8'h3C;
    send_byte(8'h3C);
    check("wr_en", rf_wr_en, 1);
    check("wr_addr", rf_addr, 5);
    check("wr_data", rf_wr_data, 8'h3C);
    idle(1);
    check("wr_busy_after", busy, 0);
    check("wr_en_once", rf_wr_en, 0);
    check("wr_addr_hold", rf_addr, 5);

    // Read frame with response 3 cycles after strobe
    send_byte(RD);
    push(K_RD, 4'hA, 8'h00);
    send_byte(8'h0A);
    check("rd_en", rf_rd_en, 1);
    check("rd_addr", rf_addr, 4'hA);
    idle(1);
    check("rd_en_once", rf_rd_en, 0);
    idle(1);
    push(K_TX, 4'h0, 8'h7E);
    rd_resp(8'h7E);
    check("tx_not_yet", tx_valid, 0);
    idle(1);
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, 8'h7E);
    idle(1);
    check("tx_once", tx_valid, 0);

    // Read with tx_full stall longer than the timeout
    send_byte(RD);
    push(K_RD, 4'hA, 8'h00);
    send_byte(8'h0A);
    idle(2);
    push(K_TX, 4'h0, 8'h7E);
    tx_full = 1'b1;
    rd_resp(8'h7E);
    cnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid || frame_err || tx_data != 8'h7E) cnt_bad++;
      idle(1);
    end
    check("stall_quiet", cnt_bad, 0);
    check("stall_busy", busy, 1);
    tx_full = 1'b0;
    idle(1);
    check("stall_tx_valid", tx_valid, 1);
    check("stall_tx_data", tx_data, 8'h7E);
    idle(1);

    // Bad opcode then a good write
    push(K_ERR, 4'h0, 8'h00);
    send_byte(8'h55);
    check("bad_op_err", frame_err, 1);
    check("bad_op_busy", busy, 0);
    wr_frame(8'h01, 8'hFF, 0, 0);
    check("wr1_en", rf_wr_en, 1);
    check("wr1_addr", rf_addr, 1);
    check("wr1_data", rf_wr_data, 8'hFF);
    idle(2);

    // Inter-byte timeout
    send_byte(WR);
    send_byte(8'h02);
    push(K_ERR, 4'h0, 8'h00);
    first   = -1;
    cnt_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (frame_err && first < 0) first = k;
      if (rf_wr_en) cnt_bad++;
    end
    check("tmo_latency", first, 15);
    check("tmo_no_wr", cnt_bad, 0);
    check("tmo_idle", busy, 0);

    // Reset mid-frame
    send_byte(WR);
    send_byte(8'h07);
    check("pre_rst_busy", busy, 1);
    RST = 1'b1;
    idle(2);
    check("rst_mid_busy", busy, 0);
    RST = 1'b0;
    idle(1);
    push(K_ERR, 4'h0, 8'h00);
    send_byte(8'h3C);
    check("post_rst_err", frame_err, 1);
    check("post_rst_no_wr", rf_wr_en, 0);
    idle(2);

    // Randomized frames
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 5))
        0, 1: wr_frame(8'($urandom), 8'($urandom),
                       $urandom_range(0, T - 2),
                       $urandom_range(0, T - 2));
        2, 3: rand_read();
        4: begin
          do b = 8'($urandom); while (b == WR || b == RD);
          push(K_ERR, 4'h0, 8'h00);
          send_byte(b);
          rd_resp(8'($urandom));
        end
        default: rand_timeout();
      endcase
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_cmd_decoder.md
Name: frame_cmd_decoder

Overview:
- Destination-domain consumer of the data synchronizer output.
- Takes each synchronized byte (sync_bus qualified by the one-cycle enable_pulse) and assembles command frames.
- Issues register-file write/read strobes and pushes read results into the TX FIFO.
- Detects malformed, overrun and stalled frames with an inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, width of received bytes, register data and TX data.
- ADDR_WIDTH, 4, register-file address width; taken from rx_data[ADDR_WIDTH-1:0], upper address-byte bits ignored.
- WR_CMD, 8'hAA, opcode for the write frame: WR_CMD, addr, data.
- RD_CMD, 8'hBB, opcode for the read frame: RD_CMD, addr.
- TIMEOUT_CYCLES, 1024, max CLK cycles allowed between bytes of one frame, or spent waiting for read data; legal range ≥ 2.

Ports:
- CLK  in  1  destination-domain clock.
- RST  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_WIDTH  synchronized byte, valid only while rx_valid is high.
- rx_valid  in  1  single-cycle byte strobe, driven by the synchronizer enable_pulse.
- rf_addr  out  ADDR_WIDTH  register-file address.
- rf_wr_data  out  DATA_WIDTH  register-file write data.
- rf_wr_en  out  1  one-cycle write strobe.
- rf_rd_en  out  1  one-cycle read strobe.
- rf_rd_data  in  DATA_WIDTH  read data, valid while rf_rd_valid is high.
- rf_rd_valid  in  1  read-data qualifier.
- tx_data  out  DATA_WIDTH  data pushed to the TX FIFO.
- tx_valid  out  1  one-cycle FIFO push strobe.
- tx_full  in  1  TX FIFO full; no push is issued while high.
- frame_err  out  1  one-cycle error pulse.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, timeout counter 0, all outputs 0. Reset asserted mid-frame aborts the frame with no strobe and no frame_err.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH.
- IDLE, rx_valid:
  - rx_data==WR_CMD -> WR_ADDR.
  - rx_data==RD_CMD -> RD_ADDR.
  - Any other value: stay IDLE; frame_err high next cycle.
- WR_ADDR, rx_valid: latch address -> WR_DATA.
- WR_DATA, rx_valid at cycle n:
  - Cycle n+1: rf_wr_en=1, rf_wr_data=rx_data, rf_addr=latched address.
  - Return to IDLE.
- RD_ADDR, rx_valid at cycle n:
  - Cycle n+1: rf_rd_en=1, rf_addr=rx_data[ADDR_WIDTH-1:0].
  - Go to RD_WAIT.
- RD_WAIT, rf_rd_valid: capture rf_rd_data into tx_data -> TX_PUSH. rf_rd_valid in any other state is ignored.
- TX_PUSH:
  - tx_full==0: tx_valid=1 for exactly one cycle, return to IDLE.
  - tx_full==1: hold tx_data stable and wait; no timeout in this state.
- rf_addr and rf_wr_data hold their last values between strobes.
- Timeout:
  - Counter clears on every state change and on every accepted rx_valid.
  - Counter increments in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - If it reaches TIMEOUT_CYCLES-1 with no rx_valid (WR/RD states) or no rf_rd_valid (RD_WAIT): frame_err pulses, state -> IDLE, no strobe issued.
  - If rx_valid arrives on the terminal count cycle, the byte is accepted and no timeout occurs.
- Overrun: rx_valid in RD_WAIT or TX_PUSH drops the byte and pulses frame_err; state and tx_data are unaffected.
- A command byte arriving after the write data byte is processed normally in IDLE. Back-to-back rx_valid on consecutive cycles is supported; each byte is consumed once.
- rf_wr_en and rf_rd_en are never high in the same cycle.

Test Plan:
- Write frame: bytes AA, 05, 3C on pulses 4 cycles apart -> one cycle after the third pulse: rf_wr_en=1, rf_addr=5, rf_wr_data=3C; busy=0 the following cycle.
- Read frame: bytes BB, 0A; rf_rd_valid with 7E 3 cycles after rf_rd_en -> rf_rd_en=1 for exactly one cycle with rf_addr=A; tx_data=7E, tx_valid=1 for one cycle.
- Read with tx_full=1 for 20 cycles, then released -> no tx_valid during the stall; single tx_valid carrying 7E in the cycle after tx_full drops.
- Bad opcode 55, then valid frame AA,01,FF -> frame_err pulse after 55; write to address 1 with FF completes normally.
- TIMEOUT_CYCLES=16: send AA, 02 then silence -> frame_err 15 cycles after the 02 pulse; state returns to IDLE; no rf_wr_en.
- RST asserted in WR_DATA, then released, then byte 3C -> no rf_wr_en; frame_err pulse because 3C is an illegal opcode in IDLE.
